noc_rr_timeout_arbiter: RTL

- Parametrised successor to the fixed 5-port router output arbiter.
- Grants one output channel to one of NPORTS input ports using round-robin priority, tracked by a one-hot grant register.
- Each port's hold time is bounded by a packet-length timeout that is captured from the head flit.
- New relative to the 5-port design:
  - grant also releases on a tail flit;
  - a timeout value of 0 means unlimited hold;
  - a per-port expiry pulse is emitted;
  - priority rotates based on the last holder, including from idle.

---
 rtl/noc_arb_pkg.sv | 32 +++
 rtl/arb_port_timer.sv | 42 ++++
 rtl/noc_rr_timeout_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/noc_arb_pkg.sv
// Shared constants and the round-robin pick helper for the NoC output arbiter.
package noc_arb_pkg;

  localparam int unsigned MAX_PORTS  = 32;
  localparam int unsigned PORT_IDX_W = 5;

  localparam logic [2:0] DEF_HEAD_ID = 3'b001;
  localparam logic [2:0] DEF_TAIL_ID = 3'b100;

  // One-hot of the first requester after 'last', wrapping within 'nports'; 'last' itself is searched last.
  function automatic logic [MAX_PORTS-1:0] rr_pick(
    input logic [MAX_PORTS-1:0] req,
    input int unsigned          last,
    input int unsigned          nports
  );
    logic [MAX_PORTS-1:0] pick;
    logic                 found;
    int unsigned          idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
      idx = last + k;
      if (idx >= nports) idx = idx - nports;
      if (!found && (k <= nports) && req[PORT_IDX_W'(idx)]) begin
        pick[PORT_IDX_W'(idx)] = 1'b1;
        found                  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_port_timer.sv
// Per-port hold timer: captures the packet-length limit from head flits and
// counts granted cycles, flagging the last permitted cycle of the hold.
module arb_port_timer
  import noc_arb_pkg::*;
#(
  parameter int unsigned     LEN_W   = 12,
  parameter int unsigned     FID_W   = 3,
  parameter logic [FID_W-1:0] HEAD_ID = FID_W'(DEF_HEAD_ID)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FID_W-1:0] flit_id,
  input  logic [LEN_W-1:0] length,
  input  logic             granted,
  input  logic             releasing,
  output logic             timeout
);

  logic [LEN_W-1:0] limit_q, limit_d;
  logic [LEN_W-1:0] count_q, count_d;

  always_comb begin
    limit_d = limit_q;
    count_d = count_q + LEN_W'(1);
    if (flit_id == HEAD_ID) limit_d = length;
    if (!granted || releasing) count_d = '0;
  end

  // A zero limit never matches, so the counter may wrap freely.
  assign timeout = granted && (limit_q != '0) && (count_q == (limit_q - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      limit_q <= '0;
      count_q <= '0;
    end else begin
      limit_q <= limit_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/noc_rr_timeout_arbiter.sv
// Round-robin output-channel arbiter with per-port packet-length timeout,
// tail-flit release and a registered per-port expiry pulse.
module noc_rr_timeout_arbiter
  import noc_arb_pkg::*;
#(
  parameter int unsigned      NPORTS  = 5,
  parameter int unsigned      LEN_W   = 12,
  parameter int unsigned      FID_W   = 3,
  parameter logic [FID_W-1:0] HEAD_ID = FID_W'(DEF_HEAD_ID),
  parameter logic [FID_W-1:0] TAIL_ID = FID_W'(DEF_TAIL_ID)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS-1:0]       req,
  input  logic [NPORTS*FID_W-1:0] flit_id,
  input  logic [NPORTS*LEN_W-1:0] length,
  output logic [NPORTS-1:0]       grant,
  output logic                    grant_valid,
  output logic [NPORTS-1:0]       expire
);

  localparam int unsigned LAST_W = $clog2(NPORTS);

  logic [NPORTS-1:0] grant_q, grant_d;
  logic              grant_valid_q, grant_valid_d;
  logic [NPORTS-1:0] expire_q, expire_d;
  logic [LAST_W-1:0] last_q, last_d;

  logic [NPORTS-1:0] timeout_c;
  logic [NPORTS-1:0] tail_c;
  logic [NPORTS-1:0] release_vec_c;
  logic              release_c;
  logic [LAST_W-1:0] holder_idx_c;

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    arb_port_timer #(
      .LEN_W  (LEN_W),
      .FID_W  (FID_W),
      .HEAD_ID(HEAD_ID)
    ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .flit_id  (flit_id[g*FID_W +: FID_W]),
      .length   (length[g*LEN_W +: LEN_W]),
      .granted  (grant_q[g]),
      .releasing(release_vec_c[g]),
      .timeout  (timeout_c[g])
    );
  end

  always_comb begin
    tail_c       = '0;
    holder_idx_c = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      tail_c[i] = (flit_id[i*FID_W +: FID_W] == TAIL_ID);
      if (grant_q[i]) holder_idx_c = LAST_W'(i);
    end
  end

  assign release_vec_c = grant_q & (~req | timeout_c | tail_c);
  assign release_c     = |release_vec_c;

  // The current holder is used as the search base so it ranks lowest even on its first granted cycle.
  always_comb begin
    last_d        = last_q;
    grant_d       = grant_q;
    expire_d      = timeout_c;
    if (grant_valid_q) last_d = holder_idx_c;
    if (!grant_valid_q || release_c) begin
      grant_d = NPORTS'(rr_pick(MAX_PORTS'(req), 32'(last_d), NPORTS));
    end
    grant_valid_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      expire_q      <= '0;
      last_q        <= LAST_W'(NPORTS - 1);
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      expire_q      <= expire_d;
      last_q        <= last_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign expire      = expire_q;

endmodule
